// File: rtl/lmi_membus_arb.sv
// Shared external memory bus arbiter and sequencer for I-fill, D-fill, uncached read and write-buffer write.
// Optional beat-gap timeout is compiled in with `define LMI_MEMBUS_TIMEOUT_EN.
module lmi_membus_arb #(
  parameter int LINE_WORDS     = 4,
  parameter int CTR_W          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IC_REQ,
  input  logic             DC_REQ,
  input  logic             UC_REQ,
  input  logic             WB_REQ,
  input  logic [31:0]      IC_ADDR,
  input  logic [31:0]      DC_ADDR,
  input  logic [31:0]      UC_ADDR,
  input  logic [31:0]      WB_ADDR,
  input  logic             WB_FULL,
  output logic             MEM_REQ,
  output logic [31:0]      MEM_ADDR,
  output logic             MEM_WR,
  output logic             MEM_BURST,
  input  logic             MEM_ACK,
  input  logic             DS_VAL,
  output logic [CTR_W-1:0] BurstCounter,
  output logic             BEAT_VAL,
  output logic             IC_GNT,
  output logic             DC_GNT,
  output logic             UC_GNT,
  output logic             WB_GNT,
  output logic             IC_DONE,
  output logic             DC_DONE,
  output logic             UC_DONE,
  output logic             WB_DONE,
  output logic             IC_OTHER_BUSY,
  output logic             DC_OTHER_BUSY,
  output logic             BUS_ERR,
  output logic [1:0]       fsm_state
);

  // Handshake: MEM_REQ is held with MEM_ADDR/MEM_WR/MEM_BURST stable until MEM_ACK is
  // sampled high; each DS_VAL in XFER is one beat; a requester holds *_REQ until its *_DONE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       gnt;        // {WB, UC, DC, IC}
  logic [3:0]       done;
  logic [3:0]       sel;
  logic [31:0]      sel_addr;
  logic [CTR_W-1:0] offset;
  logic [CTR_W-1:0] beat_cnt;
  logic [CTR_W-1:0] beat_last;
  logic             dc_pref;
  logic             timeout_hit;

  if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 ||
      (1 << CTR_W) != LINE_WORDS || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("lmi_membus_arb: inconsistent LINE_WORDS/CTR_W/TIMEOUT_CYCLES");
  end

  // Winner selection, only acted on in IDLE.
  always_comb begin
    sel = 4'b0000;
    if (WB_REQ && WB_FULL)       sel = 4'b1000;
    else if (IC_REQ && DC_REQ)   sel = dc_pref ? 4'b0010 : 4'b0001;
    else if (DC_REQ)             sel = 4'b0010;
    else if (IC_REQ)             sel = 4'b0001;
    else if (UC_REQ)             sel = 4'b0100;
    else if (WB_REQ)             sel = 4'b1000;
  end

  always_comb begin
    sel_addr = '0;
    case (sel)
      4'b0001: sel_addr = IC_ADDR;
      4'b0010: sel_addr = DC_ADDR;
      4'b0100: sel_addr = UC_ADDR;
      4'b1000: sel_addr = WB_ADDR;
      default: sel_addr = '0;
    endcase
  end

  assign beat_last = MEM_BURST ? CTR_W'(LINE_WORDS - 1) : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      gnt       <= '0;
      done      <= '0;
      MEM_REQ   <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WR    <= 1'b0;
      MEM_BURST <= 1'b0;
      offset    <= '0;
      beat_cnt  <= '0;
      dc_pref   <= 1'b1;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (|sel) begin
            gnt       <= sel;
            MEM_REQ   <= 1'b1;
            MEM_ADDR  <= sel_addr;
            MEM_WR    <= sel[3];
            MEM_BURST <= sel[0] | sel[1];
            offset    <= sel_addr[CTR_W+1:2];
            beat_cnt  <= '0;
            // The cache side just served loses the next IC/DC tie.
            if (sel[0] || sel[1]) dc_pref <= sel[0];
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (timeout_hit) begin
            MEM_REQ <= 1'b0;
            done    <= gnt;
            state   <= S_DONE;
          end else if (MEM_ACK) begin
            MEM_REQ  <= 1'b0;
            beat_cnt <= '0;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (DS_VAL) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == beat_last) begin
              done  <= gnt;
              state <= S_DONE;
            end
          end else if (timeout_hit) begin
            done  <= gnt;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // One-cycle turnaround: nothing is granted here.
          gnt       <= '0;
          MEM_ADDR  <= '0;
          MEM_WR    <= 1'b0;
          MEM_BURST <= 1'b0;
          offset    <= '0;
          beat_cnt  <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LMI_MEMBUS_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap;
  logic             bus_err;

  assign timeout_hit = (state == S_ADDR || state == S_XFER) && !DS_VAL &&
                       gap == GAP_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge CLK) begin
    if (RESET || DS_VAL || !(state == S_ADDR || state == S_XFER)) gap <= '0;
    else                                                          gap <= gap + 1'b1;
    bus_err <= !RESET && timeout_hit;
  end

  assign BUS_ERR = bus_err;
`else
  assign timeout_hit = 1'b0;
  assign BUS_ERR     = 1'b0;
`endif

  assign {WB_GNT, UC_GNT, DC_GNT, IC_GNT}     = gnt;
  assign {WB_DONE, UC_DONE, DC_DONE, IC_DONE} = done;
  assign IC_OTHER_BUSY = |gnt[3:1];
  assign DC_OTHER_BUSY = gnt[0];
  // Critical-word-first: start at the requested word and wrap within the line.
  assign BurstCounter  = offset + beat_cnt;
  assign BEAT_VAL      = (state == S_XFER) && DS_VAL;
  assign fsm_state     = state;

endmodule
